// File: rtl/psx_irq_pkg.sv
// Shared definitions for the PSX interrupt controller: source indices, register select and byte-lane helper.
package psx_irq_pkg;

  localparam int IRQ_MAX = 16;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_GPU    = 1;
  localparam int IRQ_CDROM  = 2;
  localparam int IRQ_DMA    = 3;
  localparam int IRQ_TIMER0 = 4;
  localparam int IRQ_TIMER1 = 5;
  localparam int IRQ_TIMER2 = 6;
  localparam int IRQ_CTLMEM = 7;
  localparam int IRQ_SIO    = 8;
  localparam int IRQ_SPU    = 9;
  localparam int IRQ_CTRL   = 10;

  typedef enum logic {
    REG_STAT = 1'b0,
    REG_MASK = 1'b1
  } irq_reg_e;

  // Expands the two byte enables into a per-bit write mask.
  function automatic logic [IRQ_MAX-1:0] byte_bits(input logic [1:0] ben);
    return {{8{ben[1]}}, {8{ben[0]}}};
  endfunction

endpackage

// File: rtl/psx_irq_edge_sync.sv
// One request line: SYNC_STAGES-flop synchroniser, delayed copy, and a registered one-cycle edge pulse.
module psx_irq_edge_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic line_i,
  output logic edge_o
);

  localparam logic IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = line_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    dly_d  = sync_q[SYNC_STAGES-1];
    // Active now, idle one cycle ago: a held line only fires once.
    edge_d = (sync_q[SYNC_STAGES-1] != IDLE) && (dly_q == IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{IDLE}};
      dly_q  <= IDLE;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
      edge_q <= edge_d;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/psx_irq_ctrl.sv
// PSX interrupt controller top: I_STAT/I_MASK registers and registered CPU interrupt.
// Optional sticky miss register enabled by defining PSX_IRQ_MISS_EN.
module psx_irq_ctrl
  import psx_irq_pkg::*;
#(
  parameter int NUM_IRQ     = 11,
  parameter int SYNC_STAGES = 2,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               wen,
  input  logic               addr,
  input  logic [1:0]         ben,
  input  logic [15:0]        data_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [31:0]        stat_o,
  output logic [31:0]        mask_o,
  output logic               cpu_irq_o
`ifdef PSX_IRQ_MISS_EN
  ,
  output logic [31:0]        miss_o
`endif
);

  logic [NUM_IRQ-1:0] edge_w;
  logic [NUM_IRQ-1:0] stat_q, stat_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] wr_bits, wr_data, ack_clr;
  logic [IRQ_MAX-1:0] ben_bits;
  logic               cpu_irq_q, cpu_irq_d;
  logic               stat_wr, mask_wr;

  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
      psx_irq_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .ACTIVE_LOW (ACTIVE_LOW)
      ) u_sync (
        .sys_clk(sys_clk),
        .rst    (rst),
        .line_i (irq_i[gi]),
        .edge_o (edge_w[gi])
      );
    end

    if (NUM_IRQ < IRQ_MAX) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^{ben_bits[IRQ_MAX-1:NUM_IRQ], data_i[15:NUM_IRQ]};
    end
  endgenerate

  assign ben_bits = byte_bits(ben);
  assign wr_bits  = ben_bits[NUM_IRQ-1:0];
  assign wr_data  = data_i[NUM_IRQ-1:0];
  assign stat_wr  = wen && (irq_reg_e'(addr) == REG_STAT);
  assign mask_wr  = wen && (irq_reg_e'(addr) == REG_MASK);

  always_comb begin
    ack_clr   = stat_wr ? (wr_bits & ~wr_data) : '0;
    // OR-ing the edge after the ack makes a same-cycle request win.
    stat_d    = (stat_q & ~ack_clr) | edge_w;
    mask_d    = mask_wr ? ((mask_q & ~wr_bits) | (wr_data & wr_bits)) : mask_q;
    cpu_irq_d = |(stat_q & mask_q);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      stat_q    <= '0;
      mask_q    <= '0;
      cpu_irq_q <= 1'b0;
    end else begin
      stat_q    <= stat_d;
      mask_q    <= mask_d;
      cpu_irq_q <= cpu_irq_d;
    end
  end

  assign stat_o    = {{(32-NUM_IRQ){1'b0}}, stat_q};
  assign mask_o    = {{(32-NUM_IRQ){1'b0}}, mask_q};
  assign cpu_irq_o = cpu_irq_q;

`ifdef PSX_IRQ_MISS_EN
  logic [NUM_IRQ-1:0] miss_q, miss_d;

  always_comb begin
    // A second request on an already-pending bit is only a miss if the ack does not land with it.
    miss_d = (miss_q & ~ack_clr) | (edge_w & stat_q & ~ack_clr);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      miss_q <= '0;
    end else begin
      miss_q <= miss_d;
    end
  end

  assign miss_o = {{(32-NUM_IRQ){1'b0}}, miss_q};
`endif

endmodule
